arc4_sched: RTL
===============

ARC4_SCHED -- requirements
Module: arc4_sched

Interface
REQ-001 The module SHALL take parameter TIMEOUT_CYCLES, default 1024, the per-phase watchdog limit in clk cycles (used only when ARC4_SCHED_TIMEOUT_EN is defined).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-004 The module SHALL have port en, input, 1, start request that is sampled only while rdy=1.
REQ-005 The module SHALL have port rdy, output, 1, which is 1 when idle and able to accept en.
REQ-006 The module SHALL have port phase, output, 2, the current owner: 0=none, 1=init, 2=ksa, 3=prga.
REQ-007 The module SHALL have port err, output, 1, a sticky watchdog error flag.
REQ-008 The module SHALL have ports init_en/ksa_en/prga_en, output, 1 each, the client start pulses.
REQ-009 The module SHALL have ports init_rdy/ksa_rdy/prga_rdy, input, 1 each, the client ready flags.
REQ-010 The module SHALL have ports {init,ksa,prga}_addr, input, 8 each; {init,ksa,prga}_wrdata, input, 8 each; {init,ksa,prga}_wren, input, 1 each; these are the client S-memory ports.
REQ-011 The module SHALL have ports s_addr, output, 8; s_wrdata, output, 8; s_wren, output, 1; these form the shared S-memory port.

Function
REQ-012 The module SHALL implement the states IDLE, START_INIT, WAIT_INIT, START_KSA, WAIT_KSA, START_PRGA, WAIT_PRGA, DONE and ERROR.
REQ-013 The IDLE state SHALL drive rdy=1 and phase=0; en=1 in IDLE SHALL move the FSM to START_INIT on the next edge.
REQ-014 The FSM SHALL remain in START_x until x_rdy=1, SHALL assert x_en for exactly the one cycle in which it leaves START_x, and SHALL then enter WAIT_x.
REQ-015 In WAIT_x, the FSM SHALL set an internal seen_busy flag when x_rdy=0, and SHALL advance only on x_rdy=1 with seen_busy=1; a client that stays high through the en cycle SHALL NOT advance the phase early.
REQ-016 Phase order SHALL be fixed: WAIT_INIT to START_KSA to WAIT_KSA to START_PRGA to WAIT_PRGA to DONE.
REQ-017 The DONE state SHALL hold for one cycle with rdy=0, then return to IDLE; rdy SHALL rise the cycle after DONE.
REQ-018 The memory mux SHALL be combinational on the registered state, with owner init in START_INIT/WAIT_INIT, ksa in START_KSA/WAIT_KSA and prga in START_PRGA/WAIT_PRGA; with no owner it SHALL drive s_addr=0, s_wrdata=0 and s_wren=0.
REQ-019 The mux SHALL force the wren of non-owning clients to 0, so at most one writer reaches the port in any cycle.
REQ-020 The module SHALL ignore en when rdy=0, with no queuing.
REQ-021 At most one x_en SHALL be high in any cycle.

Reset
REQ-022 Asserting rst SHALL immediately force state=IDLE, seen_busy=0, err=0 and the watchdog counter to 0, and SHALL give rdy=1, phase=0, all x_en=0 and s_wren=0.
REQ-023 An rst asserted mid-phase SHALL abort the phase; the next en SHALL restart from init.

Configuration
REQ-024 With macro ARC4_SCHED_TIMEOUT_EN defined, a counter SHALL clear on entry to each START_x, increment every cycle in START_x/WAIT_x, and on reaching TIMEOUT_CYCLES move the FSM to ERROR with err=1.
REQ-025 The ERROR state SHALL drive rdy=0 and phase=0, give the port no owner, and be left only by rst.
REQ-026 Without ARC4_SCHED_TIMEOUT_EN, no counter SHALL exist, ERROR SHALL be unreachable, and err SHALL be tied to 0.

Structure
REQ-027 Package arc4_pkg SHALL hold the state enum, the phase encoding constants (PH_NONE, PH_INIT, PH_KSA, PH_PRGA), S_DEPTH=256 and the default TIMEOUT_CYCLES.
REQ-028 The memory mux SHALL be sub-module arc4_port_mux, taking phase as input and the three client ports, and driving the s_* outputs.

Verification
REQ-029 Scenario 1: en pulse with clients that drop rdy 1 cycle after en and raise it after 256 cycles -> init_en, ksa_en and prga_en each fire once in order, phase steps 1,2,3,0, and rdy returns to 1.
REQ-030 Scenario 2: init drives addr=8'h7F, wrdata=8'h7F, wren=1 in phase 1 while ksa drives wren=1 -> s_addr=8'h7F, s_wrdata=8'h7F, s_wren=1 from init only.
REQ-031 Scenario 3: ksa_rdy held 0 at START_KSA for 10 cycles -> ksa_en stays 0 and fires on the cycle ksa_rdy rises.
REQ-032 Scenario 4: en asserted during phase 2 -> no effect, and exactly one full run completes.
REQ-033 Scenario 5: rst asserted in WAIT_KSA -> state is IDLE the same cycle with s_wren=0; a fresh en restarts with init_en.
REQ-034 Scenario 6 (ARC4_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16): prga_rdy held 0 -> err=1 at cycle 16 of the phase, stays set, and only rst clears it.

Source files
------------

// File: rtl/arc4_sched_pkg.sv
// arc4_pkg: state encoding, phase ownership codes and S-memory geometry shared by
// the ARC4 phase scheduler, its client-port mux and its interface.
package arc4_pkg;

    localparam int S_DEPTH            = 256;
    localparam int S_AW               = $clog2(S_DEPTH);
    localparam int DW                 = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_NONE = 2'd0;
    localparam phase_t PH_INIT = 2'd1;
    localparam phase_t PH_KSA  = 2'd2;
    localparam phase_t PH_PRGA = 2'd3;

    typedef enum logic [3:0] {
        IDLE,
        START_INIT,
        WAIT_INIT,
        START_KSA,
        WAIT_KSA,
        START_PRGA,
        WAIT_PRGA,
        DONE,
        ERROR
    } state_t;

    // Owner of the shared S-memory port for a given scheduler state.
    function automatic phase_t state_phase(input state_t s);
        phase_t ph;
        ph = PH_NONE;
        case (s)
            START_INIT, WAIT_INIT: ph = PH_INIT;
            START_KSA,  WAIT_KSA:  ph = PH_KSA;
            START_PRGA, WAIT_PRGA: ph = PH_PRGA;
            default:               ph = PH_NONE;
        endcase
        return ph;
    endfunction

    function automatic logic is_start(input state_t s);
        return (s == START_INIT) || (s == START_KSA) || (s == START_PRGA);
    endfunction

endpackage

// File: rtl/arc4_sched_if.sv
// arc4_sched_if: host handshake, three client handshakes/S-memory ports and the
// shared S-memory port of the ARC4 scheduler. slave = scheduler side.
interface arc4_sched_if;
    import arc4_pkg::*;

    logic            en;
    logic            rdy;
    phase_t          phase;
    logic            err;

    logic            init_en,  ksa_en,  prga_en;
    logic            init_rdy, ksa_rdy, prga_rdy;

    logic [S_AW-1:0] init_addr,   ksa_addr,   prga_addr;
    logic [DW-1:0]   init_wrdata, ksa_wrdata, prga_wrdata;
    logic            init_wren,   ksa_wren,   prga_wren;

    logic [S_AW-1:0] s_addr;
    logic [DW-1:0]   s_wrdata;
    logic            s_wren;

    modport slave (
        input  en,
        input  init_rdy, ksa_rdy, prga_rdy,
        input  init_addr, ksa_addr, prga_addr,
        input  init_wrdata, ksa_wrdata, prga_wrdata,
        input  init_wren, ksa_wren, prga_wren,
        output rdy, phase, err,
        output init_en, ksa_en, prga_en,
        output s_addr, s_wrdata, s_wren
    );

    modport master (
        output en,
        output init_rdy, ksa_rdy, prga_rdy,
        output init_addr, ksa_addr, prga_addr,
        output init_wrdata, ksa_wrdata, prga_wrdata,
        output init_wren, ksa_wren, prga_wren,
        input  rdy, phase, err,
        input  init_en, ksa_en, prga_en,
        input  s_addr, s_wrdata, s_wren
    );

endinterface

// File: rtl/arc4_sched_port_mux.sv
// arc4_port_mux: routes the owning client's S-memory port to the shared port;
// non-owners, including their write enables, never reach it.
module arc4_port_mux
    import arc4_pkg::*;
(
    input  phase_t          phase_i,
    input  logic [S_AW-1:0] init_addr_i,
    input  logic [DW-1:0]   init_wrdata_i,
    input  logic            init_wren_i,
    input  logic [S_AW-1:0] ksa_addr_i,
    input  logic [DW-1:0]   ksa_wrdata_i,
    input  logic            ksa_wren_i,
    input  logic [S_AW-1:0] prga_addr_i,
    input  logic [DW-1:0]   prga_wrdata_i,
    input  logic            prga_wren_i,
    output logic [S_AW-1:0] s_addr_o,
    output logic [DW-1:0]   s_wrdata_o,
    output logic            s_wren_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        s_addr_o   = '0;
        s_wrdata_o = '0;
        s_wren_o   = 1'b0;
        case (phase_i)
            PH_INIT: begin
                s_addr_o   = init_addr_i;
                s_wrdata_o = init_wrdata_i;
                s_wren_o   = init_wren_i;
            end
            PH_KSA: begin
                s_addr_o   = ksa_addr_i;
                s_wrdata_o = ksa_wrdata_i;
                s_wren_o   = ksa_wren_i;
            end
            PH_PRGA: begin
                s_addr_o   = prga_addr_i;
                s_wrdata_o = prga_wrdata_i;
                s_wren_o   = prga_wren_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arc4_sched.sv
// arc4_sched: sequences the init -> ksa -> prga clients and grants each the shared
// S-memory port in turn. Optional per-phase watchdog: define ARC4_SCHED_TIMEOUT_EN.
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    arc4_sched_if.slave bus
);

    state_t state_q, state_d;
    logic   seen_busy_q, seen_busy_d;
    logic   cur_rdy;

`ifdef ARC4_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    assign bus.phase = state_phase(state_q);

    assign cur_rdy = (bus.phase == PH_INIT) ? bus.init_rdy :
                     (bus.phase == PH_KSA)  ? bus.ksa_rdy  :
                     (bus.phase == PH_PRGA) ? bus.prga_rdy : 1'b0;

    always_comb begin
        state_d     = state_q;
        seen_busy_d = seen_busy_q;
        bus.rdy     = 1'b0;
        bus.init_en = 1'b0;
        bus.ksa_en  = 1'b0;
        bus.prga_en = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus.rdy = 1'b1;
                if (bus.en) state_d = START_INIT;
            end
            START_INIT: if (bus.init_rdy) begin
                bus.init_en = 1'b1;
                seen_busy_d = 1'b0;
                state_d     = WAIT_INIT;
            end
            START_KSA: if (bus.ksa_rdy) begin
                bus.ksa_en  = 1'b1;
                seen_busy_d = 1'b0;
                state_d     = WAIT_KSA;
            end
            START_PRGA: if (bus.prga_rdy) begin
                bus.prga_en = 1'b1;
                seen_busy_d = 1'b0;
                state_d     = WAIT_PRGA;
            end
            // A client still high from before its start pulse must first be seen busy.
            WAIT_INIT, WAIT_KSA, WAIT_PRGA: begin
                if (!cur_rdy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    state_d = (state_q == WAIT_INIT) ? START_KSA  :
                              (state_q == WAIT_KSA)  ? START_PRGA : DONE;
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase

`ifdef ARC4_SCHED_TIMEOUT_EN
        cnt_d = cnt_q;
        err_d = err_q;
        if (bus.phase != PH_NONE) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                state_d     = ERROR;
                err_d       = 1'b1;
                bus.init_en = 1'b0;
                bus.ksa_en  = 1'b0;
                bus.prga_en = 1'b0;
            end
        end
        if (is_start(state_d) && (state_d != state_q)) cnt_d = '0;
`endif
    end

    // NOTE: reset is asynchronous and only the control registers need it; outputs follow state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            seen_busy_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q     <= state_d;
            seen_busy_q <= seen_busy_d;
        end
    end

`ifdef ARC4_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    arc4_port_mux u_port_mux (
        .phase_i       (bus.phase),
        .init_addr_i   (bus.init_addr),
        .init_wrdata_i (bus.init_wrdata),
        .init_wren_i   (bus.init_wren),
        .ksa_addr_i    (bus.ksa_addr),
        .ksa_wrdata_i  (bus.ksa_wrdata),
        .ksa_wren_i    (bus.ksa_wren),
        .prga_addr_i   (bus.prga_addr),
        .prga_wrdata_i (bus.prga_wrdata),
        .prga_wren_i   (bus.prga_wren),
        .s_addr_o      (bus.s_addr),
        .s_wrdata_o    (bus.s_wrdata),
        .s_wren_o      (bus.s_wren)
    );

endmodule
